// File: rtl/sync_up_counter_pkg.sv
// Shared definitions for the synchronous modulo-N up counter:
// datapath mode encoding and parameter helpers.
package counter_defs;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    M_HOLD,
    M_COUNT,
    M_LOAD,
    M_WRAP
  } mode_e;

  function automatic bit width_ok(int w, int m);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) &&
           (m >= 2) && (m <= (1 << w));
  endfunction

  function automatic int term_val(int m);
    return m - 1;
  endfunction

endpackage

// File: rtl/sync_up_counter_t_cell.sv
// Single-bit toggle flip-flop on the falling edge with
// synchronous clear, load and toggle enable.
module t_cell (
  input  logic clk,
  input  logic RESET,
  input  logic i_clr,
  input  logic i_ld,
  input  logic i_d,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  always_ff @(negedge clk or negedge RESET) begin
    if (!RESET) begin
      r_q <= 1'b0;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sync_up_counter.sv
// Loadable modulo-N up counter built from toggle cells with
// lookahead toggle enables, plus cascade, compare and wrap flags.
module sync_up_counter
  import counter_defs::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] CMP,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             TC,
  output logic             CO,
  output logic             MATCH,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] TERM =
    WIDTH'(term_val(MODULUS));
  localparam logic [WIDTH:0] MOD_W =
    (WIDTH+1)'(MODULUS);

  if (!width_ok(WIDTH, MODULUS)) begin : g_bad_cfg
    $error("sync_up_counter: bad WIDTH/MODULUS");
  end

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_ld_val;
  logic [WIDTH-1:0] w_tg;
  logic             w_at_term;
  logic             w_match_nxt;
  logic             r_co;
  logic             r_match;
  logic             r_ovf;

  assign w_at_term = (w_q == TERM);
  assign w_ld_val  = ({1'b0, D} < MOD_W) ? D : TERM;

  always_comb begin
    w_mode = M_HOLD;
    unique case (1'b1)
      LOAD:                      w_mode = M_LOAD;
      !LOAD && EN && w_at_term:  w_mode = M_WRAP;
      !LOAD && EN && !w_at_term: w_mode = M_COUNT;
      default:                   w_mode = M_HOLD;
    endcase
  end

  // bit i toggles only when every lower bit is already 1
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign w_tg[i] = (w_mode == M_COUNT);
    end else begin : g_up
      assign w_tg[i] = (w_mode == M_COUNT) & (&w_q[i-1:0]);
    end

    t_cell u_cell (
      .clk   (clk),
      .RESET (RESET),
      .i_clr (w_mode == M_WRAP),
      .i_ld  (w_mode == M_LOAD),
      .i_d   (w_ld_val[i]),
      .i_t   (w_tg[i]),
      .o_q   (w_q[i])
    );
  end

  always_comb begin
    w_nxt = w_q;
    unique case (w_mode)
      M_LOAD:  w_nxt = w_ld_val;
      M_COUNT: w_nxt = w_q + 1'b1;
      M_WRAP:  w_nxt = '0;
      default: w_nxt = w_q;
    endcase
  end

  assign w_match_nxt = (w_nxt == CMP) && (w_nxt != w_q) &&
                       ({1'b0, CMP} < MOD_W);

  always_ff @(negedge clk or negedge RESET) begin
    if (!RESET) begin
      r_co    <= 1'b0;
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_co    <= (w_mode == M_WRAP);
      r_match <= w_match_nxt;
      if (w_mode == M_WRAP) begin
        r_ovf <= 1'b1;
      end else if (CLR_OVF) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign Q     = w_q;
  assign Qbar  = ~w_q;
  assign TC    = w_at_term & EN & ~LOAD;
  assign CO    = r_co;
  assign MATCH = r_match;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_sync_up_counter.sv
// Scoreboard bench for sync_up_counter: single decade stage,
// two-stage cascade and a full-range modulo-16 instance.
module tb_sync_up_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ld;
  logic [3:0] d;
  logic [3:0] cmp;
  logic       clr;
  logic [3:0] q;
  logic [3:0] qb;
  logic       tc;
  logic       co;
  logic       mt;
  logic       ovf;

  logic       c_en;
  logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
  logic       lo_tc, lo_co, lo_mt, lo_ovf;
  logic       hi_tc, hi_co, hi_mt, hi_ovf;

  logic       g_en;
  logic [3:0] g_q, g_qb;
  logic       g_tc, g_co, g_mt, g_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       co;
    logic       mt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_q;
  logic       m_ovf;

  sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clk(clk), .RESET(rst_n), .EN(en), .LOAD(ld), .D(d),
    .CMP(cmp), .CLR_OVF(clr), .Q(q), .Qbar(qb), .TC(tc),
    .CO(co), .MATCH(mt), .OVF(ovf)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .RESET(rst_n), .EN(c_en), .LOAD(1'b0),
    .D(4'd0), .CMP(4'd15), .CLR_OVF(1'b0), .Q(lo_q),
    .Qbar(lo_qb), .TC(lo_tc), .CO(lo_co), .MATCH(lo_mt),
    .OVF(lo_ovf)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .RESET(rst_n), .EN(lo_tc), .LOAD(1'b0),
    .D(4'd0), .CMP(4'd15), .CLR_OVF(1'b0), .Q(hi_q),
    .Qbar(hi_qb), .TC(hi_tc), .CO(hi_co), .MATCH(hi_mt),
    .OVF(hi_ovf)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .RESET(rst_n), .EN(g_en), .LOAD(1'b0),
    .D(4'd0), .CMP(4'd0), .CLR_OVF(1'b0), .Q(g_q),
    .Qbar(g_qb), .TC(g_tc), .CO(g_co), .MATCH(g_mt),
    .OVF(g_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic l,
                      input logic [3:0] dv, input logic c);
    exp_t       x;
    logic [3:0] nq;
    logic [3:0] eqb;
    logic       wrap;
    @(posedge clk);
    en  = e;
    ld  = l;
    d   = dv;
    clr = c;
    #1;
    check("tc", tc, (m_q == 4'd9) && e && !l);
    wrap = 1'b0;
    if (l) begin
      nq = (dv < 4'd10) ? dv : 4'd9;
    end else if (e && m_q == 4'd9) begin
      nq   = 4'd0;
      wrap = 1'b1;
    end else if (e) begin
      nq = m_q + 4'd1;
    end else begin
      nq = m_q;
    end
    if (wrap) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    x.q   = nq;
    x.co  = wrap;
    x.mt  = (nq == cmp) && (nq != m_q) && (cmp < 4'd10);
    x.ovf = m_ovf;
    m_q   = nq;
    sb.push_back(x);
    @(negedge clk);
    #1;
    x   = sb.pop_front();
    eqb = ~x.q;
    check("q", q, x.q);
    check("qbar", qb, eqb);
    check("co", co, x.co);
    check("match", mt, x.mt);
    check("ovf", ovf, x.ovf);
  endtask

  initial begin
    int cnt;
    int prev;
    rst_n = 1'b0;
    en    = 1'b0;
    ld    = 1'b0;
    d     = 4'd0;
    cmp   = 4'd4;
    clr   = 1'b0;
    c_en  = 1'b0;
    g_en  = 1'b0;
    m_q   = 4'd0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    check("rst_q", q, 4'd0);
    check("rst_qbar", qb, 4'hF);
    check("rst_co", co, 1'b0);
    check("rst_match", mt, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    repeat (12) step(1'b1, 1'b0, 4'd0, 1'b0);

    step(1'b1, 1'b1, 4'd7, 1'b0);
    step(1'b1, 1'b1, 4'd12, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);

    repeat (4) step(1'b1, 1'b0, 4'd0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd8, 1'b0);
    step(1'b0, 1'b1, 4'd4, 1'b0);

    step(1'b0, 1'b1, 4'd3, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'd9, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1);

    step(1'b0, 1'b1, 4'd5, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", q, 4'd0);
    check("arst_qbar", qb, 4'hF);
    check("arst_co", co, 1'b0);
    check("arst_match", mt, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    m_q   = 4'd0;
    m_ovf = 1'b0;
    en    = 1'b0;
    ld    = 1'b0;
    clr   = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'd0, 1'b0);

    cnt = 0;
    for (int i = 0; i < 101; i++) begin
      @(posedge clk);
      c_en = 1'b1;
      prev = cnt;
      @(negedge clk);
      #1;
      cnt = (cnt + 1) % 100;
      check("casc_cnt", 16'(hi_q * 10 + lo_q), 16'(cnt));
      check("casc_co", hi_co, prev == 99);
    end
    @(posedge clk);
    c_en = 1'b0;

    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      g_en = 1'b1;
      prev = cnt;
      @(negedge clk);
      #1;
      cnt = (cnt + 1) % 16;
      check("m16_q", g_q, 16'(cnt));
      check("m16_co", g_co, prev == 15);
    end
    @(posedge clk);
    g_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
